// File: rtl/io_bus_bridge_master_pkg.sv
// Shared definitions for the UART-to-I/O-bus bridge master: command codes,
// peripheral base addresses, FSM state and operation encodings.
package io_bus_bridge_master_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;

    // High address bytes decoded by the chip-select logic.
    localparam logic [7:0] BASE_MULT  = 8'h67;
    localparam logic [7:0] BASE_DIV   = 8'h68;
    localparam logic [7:0] BASE_UART  = 8'h69;
    localparam logic [7:0] BASE_DPRAM = 8'h70;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_GET_AH  = 4'd1,
        ST_GET_AL  = 4'd2,
        ST_GET_DH  = 4'd3,
        ST_GET_DL  = 4'd4,
        ST_REQ     = 4'd5,
        ST_ACCESS  = 4'd6,
        ST_WAIT_RD = 4'd7,
        ST_SEND_HI = 4'd8,
        ST_SEND_LO = 4'd9
    } state_t;

    typedef enum logic [1:0] {
        OP_WRITE = 2'd0,
        OP_READ  = 2'd1,
        OP_NAK   = 2'd2
    } op_t;

    function automatic op_t decode_cmd(input logic [7:0] b);
        if (b == CMD_WRITE)     return OP_WRITE;
        else if (b == CMD_READ) return OP_READ;
        else                    return OP_NAK;
    endfunction

    function automatic logic is_get_state(input state_t s);
        return (s == ST_GET_AH) || (s == ST_GET_AL) || (s == ST_GET_DH) || (s == ST_GET_DL);
    endfunction

endpackage

// File: rtl/io_bus_bridge_master_if.sv
// UART byte channel and J1 peripheral bus signals seen by the bridge master.
// rx_valid and tx_start are single-cycle pulses (no back-pressure on rx); a tx byte is
// accepted only when tx_busy is low, and the bus is owned only while bus_req && bus_gnt.
interface io_bus_bridge_master_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic        bus_req;
    logic        bus_gnt;
    logic [15:0] io_addr;
    logic [15:0] io_dout;
    logic        io_rd;
    logic        io_wr;
    logic [15:0] io_din;

    modport master (
        input  rx_data, rx_valid, tx_busy, bus_gnt, io_din,
        output tx_data, tx_start, bus_req, io_addr, io_dout, io_rd, io_wr
    );

    modport slave (
        output rx_data, rx_valid, tx_busy, bus_gnt, io_din,
        input  tx_data, tx_start, bus_req, io_addr, io_dout, io_rd, io_wr
    );
endinterface

// File: rtl/io_bus_bridge_master_timeout_ctr.sv
// Inter-byte timeout: reloads on every accepted byte, counts down while enabled and
// flags expiry on the last counted cycle unless a reload arrives in that same cycle.
module bridge_timeout_ctr #(
    parameter int unsigned RELOAD = 2500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expire
);
    localparam int W = $clog2(RELOAD + 1);

    logic [W-1:0] count;

    assign expire = en && !load && (count == W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= W'(RELOAD);
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end
endmodule

// File: rtl/io_bus_bridge_master.sv
// Second bus initiator: parses 'W'/'R' frames from the UART, performs one J1 I/O bus
// access per frame and answers with ACK, the read data, or NAK for unknown commands.
module io_bus_bridge_master
    import io_bus_bridge_master_pkg::*;
#(
    parameter int unsigned RD_LATENCY     = 1,
    parameter int unsigned TIMEOUT_CYCLES = 2500000,
    parameter logic [7:0]  ACK_BYTE       = 8'h4B,
    parameter logic [7:0]  NAK_BYTE       = 8'h3F
) (
    input  logic                  clk,
    input  logic                  rst,
    io_bus_bridge_master_if.master bus,
    output logic                  busy,
    output logic                  err,
    output state_t                state_dbg
);
    state_t      state_q, state_d;
    op_t         op_q;
    logic [15:0] addr_q;
    logic [15:0] data_q;
    logic [7:0]  tx_reg;
    logic        tx_wait;
    logic [1:0]  rd_cnt;
    logic        err_q;

    logic       in_get;
    logic       byte_load;
    logic       drop_byte;
    logic       nak_hit;
    logic       timeout;
    logic       rd_done;
    logic [7:0] cur_byte;

    assign in_get    = is_get_state(state_q);
    assign byte_load = bus.rx_valid && ((state_q == ST_IDLE) || in_get);
    assign drop_byte = bus.rx_valid && !((state_q == ST_IDLE) || in_get);
    assign nak_hit   = (state_q == ST_IDLE) && bus.rx_valid && (decode_cmd(bus.rx_data) == OP_NAK);
    assign rd_done   = (state_q == ST_WAIT_RD) && (rd_cnt == 2'(RD_LATENCY));

    bridge_timeout_ctr #(.RELOAD(TIMEOUT_CYCLES)) u_timeout (
        .clk    (clk),
        .rst_n  (rst),
        .load   (byte_load),
        .en     (in_get),
        .expire (timeout)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.rx_valid)
                    state_d = (decode_cmd(bus.rx_data) == OP_NAK) ? ST_SEND_HI : ST_GET_AH;
            end
            ST_GET_AH: begin
                if (bus.rx_valid) state_d = ST_GET_AL;
                else if (timeout) state_d = ST_IDLE;
            end
            ST_GET_AL: begin
                if (bus.rx_valid) state_d = (op_q == OP_WRITE) ? ST_GET_DH : ST_REQ;
                else if (timeout) state_d = ST_IDLE;
            end
            ST_GET_DH: begin
                if (bus.rx_valid) state_d = ST_GET_DL;
                else if (timeout) state_d = ST_IDLE;
            end
            ST_GET_DL: begin
                if (bus.rx_valid) state_d = ST_REQ;
                else if (timeout) state_d = ST_IDLE;
            end
            ST_REQ: begin
                if (bus.bus_gnt) state_d = ST_ACCESS;
            end
            // Losing the grant here means the strobe was never driven, so retry.
            ST_ACCESS: begin
                if (!bus.bus_gnt)          state_d = ST_REQ;
                else if (op_q == OP_WRITE) state_d = ST_SEND_HI;
                else                       state_d = ST_WAIT_RD;
            end
            ST_WAIT_RD: begin
                if (rd_done) state_d = ST_SEND_HI;
            end
            ST_SEND_HI: begin
                if (tx_wait) state_d = (op_q == OP_READ) ? ST_SEND_LO : ST_IDLE;
            end
            ST_SEND_LO: begin
                if (tx_wait) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.bus_req  = (state_q == ST_REQ) || (state_q == ST_ACCESS) || (state_q == ST_WAIT_RD);
        bus.io_addr  = bus.bus_req ? addr_q : 16'h0000;
        bus.io_dout  = (bus.bus_req && (op_q == OP_WRITE)) ? data_q : 16'h0000;
        bus.io_wr    = (state_q == ST_ACCESS) && bus.bus_gnt && (op_q == OP_WRITE);
        bus.io_rd    = (state_q == ST_ACCESS) && bus.bus_gnt && (op_q == OP_READ);
        bus.tx_start = ((state_q == ST_SEND_HI) || (state_q == ST_SEND_LO)) && !tx_wait && !bus.tx_busy;
        // The live byte is only presented while the transmitter is idle; otherwise the
        // last started byte is held so it stays stable for the whole transmission.
        bus.tx_data  = bus.tx_start ? cur_byte : tx_reg;
        busy         = (state_q != ST_IDLE);
        err          = err_q;
        state_dbg    = state_q;
    end

    always_comb begin
        cur_byte = NAK_BYTE;
        case (op_q)
            OP_WRITE: cur_byte = ACK_BYTE;
            OP_READ:  cur_byte = (state_q == ST_SEND_LO) ? data_q[7:0] : data_q[15:8];
            default:  cur_byte = NAK_BYTE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q    <= OP_NAK;
            addr_q  <= '0;
            data_q  <= '0;
            tx_reg  <= '0;
            tx_wait <= 1'b0;
            rd_cnt  <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q   <= drop_byte || nak_hit || timeout;
            tx_wait <= bus.tx_start;
            if (bus.tx_start) tx_reg <= cur_byte;

            if ((state_q == ST_IDLE) && bus.rx_valid) op_q <= decode_cmd(bus.rx_data);

            if (bus.rx_valid) begin
                case (state_q)
                    ST_GET_AH: addr_q[15:8] <= bus.rx_data;
                    ST_GET_AL: addr_q[7:0]  <= bus.rx_data;
                    ST_GET_DH: data_q[15:8] <= bus.rx_data;
                    ST_GET_DL: data_q[7:0]  <= bus.rx_data;
                    default: ;
                endcase
            end

            if (state_q == ST_ACCESS)       rd_cnt <= 2'd1;
            else if (state_q == ST_WAIT_RD) rd_cnt <= rd_cnt + 2'd1;

            if (rd_done) data_q <= bus.io_din;
        end
    end
endmodule

// File: tb/tb_io_bus_bridge_master.sv
// Frame-level bench for io_bus_bridge_master: a model of expected bus accesses and
// response bytes per frame, with simple UART transmitter and peripheral responders.
module tb_io_bus_bridge_master;
    localparam int unsigned T = 100;
    localparam int unsigned L = 1;

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] data;
    } bus_op_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       busy;
    logic       err;
    logic [3:0] state_dbg;

    io_bus_bridge_master_if bif();

    io_bus_bridge_master #(
        .RD_LATENCY     (L),
        .TIMEOUT_CYCLES (T),
        .ACK_BYTE       (8'h4B),
        .NAK_BYTE       (8'h3F)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bif),
        .busy      (busy),
        .err       (err),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int unsigned cyc = 0;

    bus_op_t     exp_bus[$];
    logic [7:0]  exp_tx[$];
    int          exp_err = 0;
    int          err_cnt = 0;
    int          req_cycles = 0;
    int unsigned last_byte_cyc = 0;
    int unsigned strobe_cyc = 0;
    int unsigned err_cyc = 0;
    bit          lat_check = 1'b0;
    bit          rd_pend = 1'b0;
    int unsigned rd_cyc = 0;
    logic [15:0] rd_val = '0;
    bit          start_seen = 1'b0;
    int          busy_left = 0;
    logic [7:0]  tx_hold = '0;
    bit          hold_valid = 1'b0;
    int          gnt_mode = 0;
    int unsigned gnt_release = 0;
    logic [7:0]  bases [4] = '{8'h67, 8'h68, 8'h69, 8'h70};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor: compares bus strobes and tx bytes against the expected queues.
    always @(negedge clk) begin
        bus_op_t op;
        if (rst) begin
            if (err) begin
                err_cnt++;
                err_cyc = cyc;
            end
            if (bif.bus_req) begin
                req_cycles++;
            end else begin
                check_eq("idle_addr", bif.io_addr, 32'h0);
                check_eq("idle_dout", bif.io_dout, 32'h0);
            end
            if (bif.io_wr || bif.io_rd) begin
                strobe_cyc = cyc;
                check_eq("strobe_gnt", bif.bus_gnt, 1);
                check_eq("strobe_req", bif.bus_req, 1);
                if (exp_bus.size() == 0) begin
                    check_eq("strobe_expected", exp_bus.size(), 1);
                end else begin
                    op = exp_bus.pop_front();
                    check_eq("strobe_kind", {bif.io_wr, bif.io_rd}, op.wr ? 2'b10 : 2'b01);
                    check_eq("strobe_addr", bif.io_addr, op.addr);
                    if (op.wr) begin
                        check_eq("strobe_dout", bif.io_dout, op.data);
                    end else begin
                        rd_pend = 1'b1;
                        rd_cyc  = cyc;
                        rd_val  = op.data;
                    end
                    if (lat_check) check_eq("strobe_latency", cyc - last_byte_cyc, 2);
                end
            end
            if (bif.tx_start) begin
                check_eq("start_when_idle", bif.tx_busy, 0);
                if (exp_tx.size() == 0) check_eq("tx_expected", exp_tx.size(), 1);
                else                    check_eq("tx_byte", bif.tx_data, exp_tx.pop_front());
                tx_hold    = bif.tx_data;
                hold_valid = 1'b1;
                start_seen = 1'b1;
            end else if (bif.tx_busy && hold_valid) begin
                check_eq("tx_stable", bif.tx_data, tx_hold);
            end
        end
    end

    // Responders: UART transmitter, bus arbiter and peripheral read data.
    always @(posedge clk) begin
        #1;
        if (start_seen) begin
            start_seen  = 1'b0;
            bif.tx_busy = 1'b1;
            busy_left   = $urandom_range(3, 8);
        end else if (bif.tx_busy) begin
            busy_left--;
            if (busy_left <= 0) bif.tx_busy = 1'b0;
        end
        case (gnt_mode)
            0:       bif.bus_gnt = 1'b1;
            1:       bif.bus_gnt = (cyc >= gnt_release);
            default: bif.bus_gnt = ($urandom_range(0, 3) != 0);
        endcase
        if (rd_pend && (cyc == rd_cyc + L)) begin
            bif.io_din = rd_val;
            rd_pend    = 1'b0;
        end else begin
            bif.io_din = 16'($urandom);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bif.rx_data   = b;
        bif.rx_valid  = 1'b1;
        last_byte_cyc = cyc;
        step();
        bif.rx_valid = 1'b0;
        bif.rx_data  = 8'($urandom);
        repeat (gap) step();
    endtask

    task automatic do_write(input logic [15:0] a, input logic [15:0] d, input int gap);
        exp_bus.push_back('{1'b1, a, d});
        exp_tx.push_back(8'h4B);
        send_byte(8'h57, gap);
        send_byte(a[15:8], gap);
        send_byte(a[7:0], gap);
        send_byte(d[15:8], gap);
        send_byte(d[7:0], 0);
    endtask

    task automatic do_read(input logic [15:0] a, input logic [15:0] d, input int gap);
        exp_bus.push_back('{1'b0, a, d});
        exp_tx.push_back(d[15:8]);
        exp_tx.push_back(d[7:0]);
        send_byte(8'h52, gap);
        send_byte(a[15:8], gap);
        send_byte(a[7:0], 0);
    endtask

    task automatic do_bad(input logic [7:0] b);
        exp_tx.push_back(8'h3F);
        exp_err++;
        send_byte(b, 0);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while ((busy || bif.tx_busy || exp_tx.size() != 0 || exp_bus.size() != 0) && n < 3000) begin
            step();
            n++;
        end
        check_eq({tag, "_finished"}, n < 3000, 1);
        check_eq({tag, "_err_count"}, err_cnt, exp_err);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_bus_req"}, bif.bus_req, 0);
        check_eq({tag, "_io_addr"}, bif.io_addr, 0);
        check_eq({tag, "_io_dout"}, bif.io_dout, 0);
        check_eq({tag, "_io_rd"}, bif.io_rd, 0);
        check_eq({tag, "_io_wr"}, bif.io_wr, 0);
        check_eq({tag, "_tx_start"}, bif.tx_start, 0);
        check_eq({tag, "_tx_data"}, bif.tx_data, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_err"}, err, 0);
    endtask

    task automatic apply_reset(input string tag);
        rst = 1'b0;
        exp_bus.delete();
        exp_tx.delete();
        rd_pend    = 1'b0;
        hold_valid = 1'b0;
        #1;
        check_all_zero(tag);
        repeat (2) step();
        rst = 1'b1;
        step();
    endtask

    initial begin
        logic [7:0]  b;
        logic [15:0] a;
        logic [15:0] d;
        int          k;
        int          found;

        bif.rx_data  = '0;
        bif.rx_valid = 1'b0;
        bif.tx_busy  = 1'b0;
        bif.bus_gnt  = 1'b1;
        bif.io_din   = '0;
        #1 rst = 1'b0;
        repeat (3) step();
        check_all_zero("reset");
        rst = 1'b1;
        repeat (2) step();

        // Directed write and read frames with the bus already granted.
        lat_check = 1'b1;
        do_write(16'h7005, 16'h1234, 0);
        wait_done("write");
        do_read(16'h6702, 16'hBEEF, 0);
        wait_done("read");

        // Unknown command: NAK only, no bus request.
        req_cycles = 0;
        do_bad(8'h41);
        wait_done("nak");
        check_eq("nak_no_req", req_cycles, 0);

        // Inter-byte timeout after a partial write frame.
        req_cycles = 0;
        send_byte(8'h57, 0);
        send_byte(8'h68, 0);
        k = int'(last_byte_cyc);
        exp_err++;
        for (int i = 0; i < int'(T) + 20; i++) begin
            if (err_cnt == exp_err) break;
            step();
        end
        check_eq("timeout_err", err_cnt, exp_err);
        check_eq("timeout_window", (int'(err_cyc) - k >= int'(T) - 1) && (int'(err_cyc) - k <= int'(T) + 1), 1);
        step();
        check_eq("timeout_idle", busy, 0);
        check_eq("timeout_no_req", req_cycles, 0);
        do_read(16'h6905, 16'h5AA5, 0);
        wait_done("after_timeout");

        // Gaps just under the timeout keep the frame alive.
        do_write(16'h6810, 16'hC3E1, int'(T) - 5);
        wait_done("long_gap");

        // Grant withheld: request held, strobe right after grant, stray byte dropped.
        lat_check   = 1'b0;
        gnt_mode    = 1;
        gnt_release = cyc + 60;
        req_cycles  = 0;
        do_read(16'h7010, 16'h0F0F, 0);
        repeat (20) step();
        check_eq("gnt_wait_busy", busy, 1);
        exp_err++;
        send_byte(8'h55, 0);
        wait_done("gnt_wait");
        check_eq("gnt_req_held", req_cycles >= 50, 1);
        check_eq("gnt_strobe_cycle", strobe_cyc, gnt_release + 1);
        gnt_mode = 0;
        step();

        // Reset during the read strobe cycle.
        lat_check = 1'b1;
        do_read(16'h6701, 16'h1111, 0);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bif.io_rd) begin
                found = 1;
                break;
            end
        end
        check_eq("rst_rd_seen", found, 1);
        apply_reset("rst_in_rd");
        do_write(16'h7001, 16'hA5A5, 0);
        wait_done("after_rst_rd");

        // Reset while the transmitter is busy; no stale byte afterwards.
        do_write(16'h6902, 16'h2222, 0);
        found = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bif.tx_busy) begin
                found = 1;
                break;
            end
        end
        check_eq("rst_txbusy_seen", found, 1);
        apply_reset("rst_in_tx");
        repeat (30) step();
        do_read(16'h7033, 16'h9C7E, 1);
        wait_done("after_rst_tx");

        // Randomised frames across peripherals, gaps and grant behaviour.
        for (int f = 0; f < 24; f++) begin
            gnt_mode  = ($urandom_range(0, 1) == 0) ? 0 : 2;
            lat_check = (gnt_mode == 0);
            a = {bases[$urandom_range(0, 3)], 8'($urandom)};
            d = 16'($urandom);
            k = $urandom_range(0, 9);
            if (k == 0) begin
                do
                    b = 8'($urandom);
                while (b == 8'h57 || b == 8'h52);
                do_bad(b);
            end else if (k < 5) begin
                do_write(a, d, $urandom_range(0, 4));
            end else begin
                do_read(a, d, $urandom_range(0, 4));
            end
            wait_done("random");
        end

        gnt_mode = 0;
        repeat (40) step();
        check_eq("final_err_count", err_cnt, exp_err);
        check_eq("final_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
